uart_rx_path: RTL
=================

# uart_rx_path

Receive side of the inter-board UART link: oversamples the serial `rx` line, deframes 8N1 characters and buffers them in a small first-word-fall-through FIFO. It feeds the UART protocol interface (WAIT handshake / score exchange) directly through `r_data` (its `get_uart`), `rx_empty` and `rd_uart`. It also flags framing errors and FIFO overruns to the game logic.

## Interface
- `DVSR`, 54, baud-tick divider; one tick every DVSR clocks (100 MHz / (16·115200))
- `DBIT`, 8, data bits per character
- `SB_TICK`, 16, ticks per stop bit
- `FIFO_W`, 2, FIFO address width; depth = 2^FIFO_W

- `clk`  in  1  system clock, all logic rising-edge
- `rst`  in  1  reset: one clock, synchronous, active-low (`rst`=0 resets)
- `rx`  in  1  asynchronous serial input, idle high
- `rd_uart`  in  1  pop request; one pop per clocked high cycle
- `r_data`  out  8  FIFO head byte, valid only while `rx_empty`=0
- `rx_empty`  out  1  FIFO empty
- `rx_full`  out  1  FIFO full
- `frame_err`  out  1  one-clock pulse: stop bit sampled low
- `rx_overrun`  out  1  one-clock pulse: completed byte dropped, FIFO full

## Operation
- Reset state: `rx` synchronizer = 1, tick counter = 0, FSM IDLE, pointers/count = 0, `rx_empty`=1, `rx_full`=0, `frame_err`=0, `rx_overrun`=0. FIFO storage is not reset.
- `rx` passes through a 2-FF synchronizer. All FSM decisions use the synchronized value `rxs`.
- Baud tick: counter 0..DVSR-1, wraps to 0. `tick` is high for one clock when count = DVSR-1. The counter is free-running.
- Rx FSM uses a tick count `s` (4 bit), a bit count `n` (3 bit) and a shift register `b` (8 bit):
  - IDLE: `rxs`=0 → START, `s`=0.
  - START: on tick, if `s`=7 (mid-bit): `rxs`=0 → DATA, `s`=0, `n`=0; `rxs`=1 → IDLE (glitch rejected). Otherwise `s`++.
  - DATA: on tick, if `s`=15: `b`={`rxs`,`b[7:1]`} (LSB first), `s`=0. If `n`=DBIT-1 → STOP, else `n`++. Otherwise `s`++.
  - STOP: on tick, if `s`=SB_TICK-1: `rxs`=1 → done (push `b`); `rxs`=0 → `frame_err` pulse, no push. Both → IDLE. Otherwise `s`++.
- FIFO (FWFT): `r_data` = mem[rd_ptr]. Pointers wrap modulo 2^FIFO_W. Occupancy count is FIFO_W+1 bits.
  - push = done ∧ (¬full ∨ pop); done ∧ full ∧ ¬pop → byte dropped, `rx_overrun` pulse.
  - pop = `rd_uart` ∧ ¬empty; `rd_uart` while empty is ignored.
  - Simultaneous push+pop when full: both occur, count unchanged, `rx_full` stays 1.
  - Simultaneous push+pop when empty: pop ignored, push occurs.
- A low `rst` mid-character aborts it: the partial byte is discarded and all FIFO contents are lost.

## Timing
- `rx` edge to `rxs`: 2 clocks.
- Byte enters FIFO on the clock after the final stop-bit tick. `rx_empty` falls and `r_data` is valid at that same edge.
- Pop: `r_data`, `rx_empty` and `rx_full` update on the edge that samples `rd_uart`=1. The next byte is visible the following cycle.
- The downstream interface registers `rd_uart`, so `rd_uart` can arrive one cycle late. The FIFO must never pop twice for a single byte while empty (guarded by the ¬empty condition).
- `frame_err` and `rx_overrun` are registered single-clock pulses, asserted the clock after the stop-bit decision.
- Full character = 7+1 + 16·DBIT + SB_TICK ticks from start-edge detection.

## Structure
- Shared header/package `uart_pkg`: DBIT, SB_TICK, default DVSR, FIFO_W, `WAIT_STATE_SIGNAL` = 8'hFF. FSM state encodings are local to this block.
- One sub-module: `uart_fifo` (parameterised width/depth, FWFT, full/empty). The transmit path reuses it.
- Baud-tick counter, synchronizer and FSM live in the top level.

## Test plan
- Reset (`rst`=0 for 2 clocks, `rx`=1) → `rx_empty`=1, `rx_full`=0, no pulses. The FSM stays IDLE for 1000 clocks.
- `DVSR`=4: send 0xFF then 0x2A at 8N1 → `rx_empty` falls, `r_data`=0xFF. Pulse `rd_uart` → `r_data`=0x2A. Pulse again → `rx_empty`=1.
- `rx` low for 5 ticks, then high → no push, FSM back to IDLE, no `frame_err`.
- Send 0x55 with the stop bit driven low → one `frame_err` pulse, `rx_empty` stays 1.
- Send 0x01..0x05 with no reads → `rx_full`=1 after 0x04, 0x05 dropped with one `rx_overrun` pulse. Reads return 0x01..0x04. Repeat with `rd_uart` asserted on the push cycle of 0x05 → 0x05 retained, no overrun.
- Drive `rst` low mid-DATA of 0xA5 with one byte already buffered → `rx_empty`=1 next clock. A subsequent clean 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receive and transmit paths.
package uart_pkg;

  localparam int UART_DVSR    = 54;   // 100 MHz / (16 * 115200)
  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;
  localparam int UART_FIFO_W  = 2;

  localparam logic [7:0] WAIT_STATE_SIGNAL = 8'hFF;

  // Number of bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with full/empty flags; the head word is always on o_r_data.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = UART_FIFO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_w_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_r_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a write.
  assign w_pop    = i_rd & ~o_empty;
  assign w_push   = i_wr & (~o_full | w_pop);
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (ADDR_W + 1)'(DEPTH));
  assign o_r_data = r_mem[r_rd_ptr];

  // NOTE: storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: rx synchronizer, baud tick, 8N1 deframing FSM and FWFT receive FIFO.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int DVSR    = UART_DVSR,
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int FIFO_W  = UART_FIFO_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            rx_overrun
);

  localparam int TICK_W = cnt_width(DVSR - 1);
  localparam int N_W    = cnt_width(DBIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  logic              r_sync1;
  logic              r_rxs;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  rx_state_t         r_state;
  logic [3:0]        r_s;
  logic [N_W-1:0]    r_n;
  logic [DBIT-1:0]   r_b;
  logic              r_done;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_empty;
  logic              w_full;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_W'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (!rst)        r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // NOTE: all state and outputs use <= so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!r_rxs) begin
            r_state <= ST_START;
            r_s     <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_s == 4'd7) begin
              // A line that is high again at mid-start-bit was a glitch.
              if (!r_rxs) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_s == 4'd15) begin
              r_b <= {r_rxs, r_b[DBIT-1:1]};
              r_s <= '0;
              if (r_n == N_W'(DBIT - 1)) r_state <= ST_STOP;
              else                       r_n     <= r_n + 1'b1;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_s == 4'(SB_TICK - 1)) begin
              if (r_rxs) r_done      <= 1'b1;
              else       r_frame_err <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A completed byte is lost only when the FIFO is full and nothing is popped that edge.
  always_ff @(posedge clk) begin
    if (!rst) r_overrun <= 1'b0;
    else      r_overrun <= r_done & w_full & ~rd_uart;
  end

  uart_fifo #(
    .WIDTH  (DBIT),
    .ADDR_W (FIFO_W)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr     (r_done),
    .i_w_data (r_b),
    .i_rd     (rd_uart),
    .o_r_data (r_data),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  assign rx_empty   = w_empty;
  assign rx_full    = w_full;
  assign frame_err  = r_frame_err;
  assign rx_overrun = r_overrun;

endmodule
